mrv1_wb_arb: RTL

Writeback arbiter directly downstream of the execute stage. It collects per-FU completion results (done/data/itag/tid from the INT, MUL, MEM and SYS units) into one holding slot per FU. It then round-robin arbitrates them onto the single register-file write port and scoreboard-release bus. It also reports per-FU slot occupancy back to issue, because the FUs have no output backpressure.

---
 rtl/mrv1_wb_arb_pkg.sv | 22 ++
 rtl/mrv1_wb_arb_if.sv | 40 ++++
 rtl/mrv1_wb_arb_rr.sv | 30 +++
 rtl/mrv1_wb_arb.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mrv1_wb_arb_pkg.sv
// mrv1 writeback arbiter shared types and constants.
// Holds FU indices, default widths and the held-result bundle.
package mrv1_pkg;

    localparam int MRV_FU_TYPE_INT = 0;
    localparam int MRV_FU_TYPE_MUL = 1;
    localparam int MRV_FU_TYPE_MEM = 2;
    localparam int MRV_FU_TYPE_SYS = 3;
    localparam int MRV_NUM_FU      = 4;

    localparam int MRV_DATA_W      = 32;
    localparam int MRV_ITAG_W      = 3;
    localparam int MRV_NUM_THREADS = 8;
    localparam int MRV_TID_W       = $clog2(MRV_NUM_THREADS);

    typedef struct packed {
        logic [MRV_DATA_W-1:0] data;
        logic [MRV_ITAG_W-1:0] itag;
        logic [MRV_TID_W-1:0]  tid;
    } mrv1_wb_res_t;

endpackage

// File: rtl/mrv1_wb_arb_if.sv
// mrv1 writeback arbiter bus: FU completions in, writeback out.
// slave = arbiter side, master = execute/regfile side.
interface mrv1_wb_arb_if
    import mrv1_pkg::*;
#(
    parameter int NUM_FU_P      = MRV_NUM_FU,
    parameter int DATA_WIDTH_P  = MRV_DATA_W,
    parameter int ITAG_WIDTH_P  = MRV_ITAG_W,
    parameter int NUM_THREADS_P = MRV_NUM_THREADS
);
    localparam int TID_WIDTH_LP    = $clog2(NUM_THREADS_P);
    localparam int FU_IDX_WIDTH_LP = $clog2(NUM_FU_P);

    logic [NUM_FU_P-1:0]                   exec_fu_done_i;
    logic [NUM_FU_P-1:0][DATA_WIDTH_P-1:0] exec_fu_res_data_i;
    logic [NUM_FU_P-1:0][ITAG_WIDTH_P-1:0] exec_fu_itag_i;
    logic [NUM_FU_P-1:0][TID_WIDTH_LP-1:0] exec_fu_tid_i;
    logic [NUM_FU_P-1:0]                   wb_fu_busy_o;
    logic                                  wb_vld_o;
    logic [DATA_WIDTH_P-1:0]               wb_data_o;
    logic [ITAG_WIDTH_P-1:0]               wb_itag_o;
    logic [TID_WIDTH_LP-1:0]               wb_tid_o;
    logic [FU_IDX_WIDTH_LP-1:0]            wb_fu_o;
    logic                                  wb_ovf_o;

    modport slave (
        input  exec_fu_done_i, exec_fu_res_data_i,
        input  exec_fu_itag_i, exec_fu_tid_i,
        output wb_fu_busy_o, wb_vld_o, wb_data_o,
        output wb_itag_o, wb_tid_o, wb_fu_o, wb_ovf_o
    );

    modport master (
        output exec_fu_done_i, exec_fu_res_data_i,
        output exec_fu_itag_i, exec_fu_tid_i,
        input  wb_fu_busy_o, wb_vld_o, wb_data_o,
        input  wb_itag_o, wb_tid_o, wb_fu_o, wb_ovf_o
    );

endinterface

// File: rtl/mrv1_wb_arb_rr.sv
// Round-robin arbiter: first request at or after ptr, wrapping.
// Pure combinational; pointer lives in the caller.
module mrv1_rr_arb #(
    parameter int N_P = 4
) (
    input  logic [N_P-1:0]         i_req,
    input  logic [$clog2(N_P)-1:0] i_ptr,
    output logic [N_P-1:0]         o_gnt,
    output logic [$clog2(N_P)-1:0] o_idx,
    output logic                   o_vld
);

    // scan N_P positions starting at the pointer, take the first hit
    always_comb begin
        int k;
        k     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        for (int i = 0; i < N_P; i++) begin
            k = (int'(i_ptr) + i) % N_P;
            if (!o_vld && i_req[k]) begin
                o_vld    = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = $clog2(N_P)'(k);
            end
        end
    end

endmodule

// File: rtl/mrv1_wb_arb.sv
// Writeback arbiter: per-FU holding slots, RR onto one write port.
// Optional same-cycle bypass of empty slots: MRV1_WB_BYPASS_EN.
module mrv1_wb_arb
    import mrv1_pkg::*;
#(
    parameter int NUM_FU_P      = MRV_NUM_FU,
    parameter int DATA_WIDTH_P  = MRV_DATA_W,
    parameter int ITAG_WIDTH_P  = MRV_ITAG_W,
    parameter int NUM_THREADS_P = MRV_NUM_THREADS
) (
    input logic            clk_i,
    input logic            rst_ni,
    mrv1_wb_arb_if.slave   bus
);
    localparam int TID_WIDTH_LP    = $clog2(NUM_THREADS_P);
    localparam int FU_IDX_WIDTH_LP = $clog2(NUM_FU_P);

    logic [NUM_FU_P-1:0]        r_slot_vld;
    mrv1_wb_res_t               r_slot [NUM_FU_P];
    logic [FU_IDX_WIDTH_LP-1:0] r_ptr;
    logic                       r_ovf;
    logic                       r_wb_vld;
    mrv1_wb_res_t               r_wb_res;
    logic [FU_IDX_WIDTH_LP-1:0] r_wb_fu;

    mrv1_wb_res_t               w_in [NUM_FU_P];
    mrv1_wb_res_t               w_sel;
    logic [NUM_FU_P-1:0]        w_req;
    logic [NUM_FU_P-1:0]        w_gnt;
    logic [FU_IDX_WIDTH_LP-1:0] w_idx;
    logic                       w_any;
    logic [NUM_FU_P-1:0]        w_cap;
    logic [NUM_FU_P-1:0]        w_drop;
    logic [NUM_FU_P-1:0]        w_vld_nxt;

`ifdef MRV1_WB_BYPASS_EN
    assign w_req = r_slot_vld | bus.exec_fu_done_i;
`else
    assign w_req = r_slot_vld;
`endif

    mrv1_rr_arb #(
        .N_P   (NUM_FU_P)
    ) u_rr (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_vld (w_any)
    );

    // per-slot capture, overflow detect and next-valid
    always_comb begin
        w_cap     = '0;
        w_drop    = '0;
        w_vld_nxt = '0;
        for (int f = 0; f < NUM_FU_P; f++) begin
            w_in[f].data = bus.exec_fu_res_data_i[f];
            w_in[f].itag = bus.exec_fu_itag_i[f];
            w_in[f].tid  = bus.exec_fu_tid_i[f];
`ifdef MRV1_WB_BYPASS_EN
            // empty+granted goes straight out; only hold on refill or loss of arb
            w_cap[f] = bus.exec_fu_done_i[f] &
                       (r_slot_vld[f] ? w_gnt[f] : !w_gnt[f]);
`else
            w_cap[f] = bus.exec_fu_done_i[f] &
                       (!r_slot_vld[f] | w_gnt[f]);
`endif
            w_drop[f]    = bus.exec_fu_done_i[f] & r_slot_vld[f] & !w_gnt[f];
            w_vld_nxt[f] = w_cap[f] | (r_slot_vld[f] & !w_gnt[f]);
        end
    end

    // select granted result: held slot, or the live input when bypassing
    always_comb begin
        w_sel = r_slot[w_idx];
`ifdef MRV1_WB_BYPASS_EN
        if (!r_slot_vld[w_idx]) begin
            w_sel = w_in[w_idx];
        end
`endif
    end

    // slot state, RR pointer and sticky overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_slot_vld <= '0;
            r_ptr      <= '0;
            r_ovf      <= 1'b0;
            for (int f = 0; f < NUM_FU_P; f++) begin
                r_slot[f] <= '0;
            end
        end else begin
            r_slot_vld <= w_vld_nxt;
            if (|w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_any) begin
                r_ptr <= (int'(w_idx) == NUM_FU_P - 1) ? '0 :
                         w_idx + FU_IDX_WIDTH_LP'(1);
            end
            for (int f = 0; f < NUM_FU_P; f++) begin
                if (w_cap[f]) begin
                    r_slot[f] <= w_in[f];
                end
            end
        end
    end

    // writeback register: valid every cycle, payload only on grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wb_vld <= 1'b0;
            r_wb_res <= '0;
            r_wb_fu  <= '0;
        end else begin
            r_wb_vld <= w_any;
            if (w_any) begin
                r_wb_res <= w_sel;
                r_wb_fu  <= w_idx;
            end
        end
    end

    assign bus.wb_fu_busy_o = r_slot_vld;
    assign bus.wb_vld_o     = r_wb_vld;
    assign bus.wb_data_o    = r_wb_res.data;
    assign bus.wb_itag_o    = r_wb_res.itag;
    assign bus.wb_tid_o     = r_wb_res.tid;
    assign bus.wb_fu_o      = r_wb_fu;
    assign bus.wb_ovf_o     = r_ovf;

endmodule
